// File: rtl/fpga_input_ctrl.sv
// Board input front end: synchronizes, debounces and edge-captures two buttons and NUM_SW
// switches, exposing them as a small read-only register file with clear-on-read event flags.
module fpga_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_SW          = 10
) (
  input  logic              Clock,
  input  logic              Rst_N,
  input  logic              Button_0,
  input  logic              Button_1,
  input  logic [NUM_SW-1:0] Switch,
  input  logic              Rd_En,
  input  logic [1:0]        Rd_Addr,
  output logic [31:0]       Rd_Data,
  output logic              Rd_Valid,
  output logic              Irq
);

  localparam int unsigned NB   = NUM_SW + 2;
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  // Bit order everywhere: {switches, button_1, button_0}; buttons are active-low on the pins.
  localparam logic [NB-1:0] BtnMask = NB'(2'b11);

  localparam logic [1:0] AddrSwState   = 2'd0;
  localparam logic [1:0] AddrBtnState  = 2'd1;
  localparam logic [1:0] AddrBtnEvents = 2'd2;
  localparam logic [1:0] AddrSwChange  = 2'd3;

  logic [NB-1:0]     w_raw;
  logic [NB-1:0]     r_sync1;
  logic [NB-1:0]     r_sync2;
  logic [NB-1:0]     w_sync_pol;
  logic [NB-1:0]     r_stable;
  logic [NB-1:0]     w_stable_d;
  logic [NB-1:0]     w_accept;
  logic [CntW-1:0]   r_cnt [NB];
  logic [CntW-1:0]   w_cnt_d [NB];

  logic [1:0]        w_press_set;
  logic [1:0]        w_rel_set;
  logic [NUM_SW-1:0] w_chg_set;
  logic [3:0]        r_events;
  logic [3:0]        w_events_d;
  logic [NUM_SW-1:0] r_sw_chg;
  logic [NUM_SW-1:0] w_sw_chg_d;

  logic              w_clr_btn;
  logic              w_clr_sw;
  logic [31:0]       w_rd_mux;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_irq;

  assign w_raw = {Switch, Button_1, Button_0};

  // Convert to "pressed = 1" polarity so stable state and comparisons share one sense.
  assign w_sync_pol = r_sync2 ^ BtnMask;

  always_comb begin
    for (int i = 0; i < int'(NB); i++) begin
      w_accept[i] = 1'b0;
      w_cnt_d[i]  = r_cnt[i] + CntW'(1);
      if (w_sync_pol[i] == r_stable[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CntMax) begin
        w_accept[i] = 1'b1;
        w_cnt_d[i]  = '0;
      end
    end
  end

  assign w_stable_d  = r_stable ^ w_accept;
  assign w_press_set = w_accept[1:0] & w_stable_d[1:0];
  assign w_rel_set   = w_accept[1:0] & ~w_stable_d[1:0];
  assign w_chg_set   = w_accept[NB-1:2];

  assign w_clr_btn = Rd_En && (Rd_Addr == AddrBtnEvents);
  assign w_clr_sw  = Rd_En && (Rd_Addr == AddrSwChange);

  // Set terms are OR-ed after the clear so an event landing on the read edge survives.
  assign w_events_d = (w_clr_btn ? 4'b0 : r_events) | {w_rel_set, w_press_set};
  assign w_sw_chg_d = (w_clr_sw ? '0 : r_sw_chg) | w_chg_set;

  always_comb begin
    w_rd_mux = '0;
    unique case (Rd_Addr)
      AddrSwState:   w_rd_mux = 32'(r_stable[NB-1:2]);
      AddrBtnState:  w_rd_mux = 32'(r_stable[1:0]);
      AddrBtnEvents: w_rd_mux = 32'(r_events);
      AddrSwChange:  w_rd_mux = 32'(r_sw_chg);
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Rst_N) begin
      r_sync1    <= BtnMask;
      r_sync2    <= BtnMask;
      r_stable   <= '0;
      r_events   <= '0;
      r_sw_chg   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
      for (int i = 0; i < int'(NB); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable   <= w_stable_d;
      r_events   <= w_events_d;
      r_sw_chg   <= w_sw_chg_d;
      r_rd_valid <= Rd_En;
      r_irq      <= |w_events_d;
      if (Rd_En) begin
        r_rd_data <= w_rd_mux;
      end
      for (int i = 0; i < int'(NB); i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign Rd_Data  = r_rd_data;
  assign Rd_Valid = r_rd_valid;
  assign Irq      = r_irq;

endmodule

// File: tb/tb_fpga_input_ctrl.sv
// Bench for fpga_input_ctrl: a window-based reference model checked every cycle, plus
// directed scenarios with literal expected register values.
module tb_fpga_input_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned NS = 10;
  localparam logic [11:0] IdleRaw = 12'h003;

  logic          clk;
  logic          rst_n;
  logic          btn0;
  logic          btn1;
  logic [NS-1:0] sw;
  logic          rd_en;
  logic [1:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          irq;

  int n_cmp;
  int n_err;

  fpga_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .NUM_SW         (NS)
  ) u_dut (
    .Clock   (clk),
    .Rst_N   (rst_n),
    .Button_0(btn0),
    .Button_1(btn1),
    .Switch  (sw),
    .Rd_En   (rd_en),
    .Rd_Addr (rd_addr),
    .Rd_Data (rd_data),
    .Rd_Valid(rd_valid),
    .Irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a bit is accepted when the last D synchronized samples (raw delayed
  // by two edges) all disagree with its current stable value.
  logic [11:0] hist [0:D+1];
  logic [11:0] m_stable;
  logic [3:0]  m_ev;
  logic [9:0]  m_chg;
  logic [31:0] m_rd_data;
  logic        m_rd_valid;
  logic        m_irq;
  logic        m_init;
  logic [11:0] m_acc;
  logic [11:0] m_ns;
  logic [3:0]  m_ev_set;

  initial m_init = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= D + 1; i++) hist[i] = IdleRaw;
      m_stable   = '0;
      m_ev       = '0;
      m_chg      = '0;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_irq      = 1'b0;
    end else begin
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {sw, btn1, btn0};
      m_acc = '1;
      for (int k = 2; k <= D + 1; k++) m_acc = m_acc & ((hist[k] ^ IdleRaw) ^ m_stable);
      m_ns = m_stable ^ m_acc;
      m_ev_set = {m_acc[1:0] & ~m_ns[1:0], m_acc[1:0] & m_ns[1:0]};
      if (rd_en) begin
        case (rd_addr)
          2'd0: m_rd_data = {22'd0, m_stable[11:2]};
          2'd1: m_rd_data = {30'd0, m_stable[1:0]};
          2'd2: m_rd_data = {28'd0, m_ev};
          default: m_rd_data = {22'd0, m_chg};
        endcase
        if (rd_addr == 2'd2) m_ev = '0;
        if (rd_addr == 2'd3) m_chg = '0;
      end
      m_ev       = m_ev | m_ev_set;
      m_chg      = m_chg | m_acc[11:2];
      m_stable   = m_ns;
      m_rd_valid = rd_en;
      m_irq      = |m_ev;
    end
    m_init = 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      n_cmp++;
      if (rd_data !== m_rd_data) begin
        n_err++;
        $display("FAIL model rd_data t=%0t: got %h want %h", $time, rd_data, m_rd_data);
      end
      n_cmp++;
      if (rd_valid !== m_rd_valid) begin
        n_err++;
        $display("FAIL model rd_valid t=%0t: got %b want %b", $time, rd_valid, m_rd_valid);
      end
      n_cmp++;
      if (irq !== m_irq) begin
        n_err++;
        $display("FAIL model irq t=%0t: got %b want %b", $time, irq, m_irq);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input string name, input logic [1:0] a, input logic [31:0] want);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(name, rd_data, want);
  endtask

  task automatic idle_reset();
    btn0   = 1'b1;
    btn1   = 1'b1;
    sw     = '0;
    rd_en  = 1'b0;
    rst_n  = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    btn0    = 1'b0;
    btn1    = 1'b1;
    sw      = 10'h3FF;
    rd_en   = 1'b0;
    rd_addr = 2'd0;

    // Reset with active inputs: outputs idle, acceptance only 6 edges after release.
    wait_neg(3);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n   = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 2'd1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("rst_btn_state", rd_data, (k >= 7) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;

    // Press, read-clear, then release flag.
    idle_reset();
    btn0 = 1'b0;
    wait_neg(5);
    chk("press_irq_early", {31'd0, irq}, 32'd0);
    wait_neg(1);
    chk("press_irq", {31'd0, irq}, 32'd1);
    do_read("press_state", 2'd1, 32'h1);
    do_read("press_ev1", 2'd2, 32'h1);
    do_read("press_ev2", 2'd2, 32'h0);
    chk("press_irq_clr", {31'd0, irq}, 32'd0);
    btn0 = 1'b1;
    wait_neg(8);
    do_read("release_ev", 2'd2, 32'h4);

    // Glitch shorter than D is ignored; a D-cycle pulse gives press then release.
    idle_reset();
    btn1 = 1'b0;
    wait_neg(3);
    btn1 = 1'b1;
    wait_neg(8);
    do_read("glitch_state", 2'd1, 32'h0);
    do_read("glitch_ev", 2'd2, 32'h0);
    btn1 = 1'b0;
    wait_neg(4);
    btn1 = 1'b1;
    wait_neg(2);
    do_read("pulse_press", 2'd2, 32'h2);
    wait_neg(4);
    do_read("pulse_release", 2'd2, 32'h8);

    // Switches.
    idle_reset();
    sw = 10'h205;
    wait_neg(8);
    do_read("sw_state", 2'd0, 32'h205);
    do_read("sw_chg1", 2'd3, 32'h205);
    do_read("sw_chg2", 2'd3, 32'h0);

    // Read on the exact edge the press is accepted: set wins over clear.
    idle_reset();
    btn0 = 1'b0;
    wait_neg(5);
    do_read("coll_ev1", 2'd2, 32'h0);
    chk("coll_irq1", {31'd0, irq}, 32'd1);
    wait_neg(1);
    chk("coll_irq2", {31'd0, irq}, 32'd1);
    do_read("coll_ev2", 2'd2, 32'h1);

    // Reset mid-debounce restarts the count.
    idle_reset();
    btn0 = 1'b0;
    wait_neg(3);
    rst_n = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(5);
    chk("mid_rst_irq_early", {31'd0, irq}, 32'd0);
    wait_neg(1);
    chk("mid_rst_irq", {31'd0, irq}, 32'd1);
    do_read("mid_rst_ev", 2'd2, 32'h1);

    wait_neg(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
